// File: rtl/data_sample_scheduler.sv
// data_sample_scheduler: on each period tick, samples the enabled channels in turn over one shared 8-bit path.
// Macro DATA_SAMPLE_SCHED_OVERRUN_CNT_EN adds the saturating dropped-tick counter; otherwise overrun_cnt reads 0.
module data_sample_scheduler #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2,
    parameter int SETTLE = 2,
    parameter int PER_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [PER_W-1:0]  period,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [7:0]        adc_data,
    output logic [CH_W-1:0]   mux_sel,
    output logic [7:0]        sample_data,
    output logic [CH_W-1:0]   sample_ch,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              busy,
    input  logic              clr_overrun,
    output logic              overrun,
    output logic [7:0]        overrun_cnt
);
    localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SC_W-1:0] SC_LOAD = SC_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [PER_W-1:0]    tcnt_q;
    logic [PER_W-1:0]    per_last;
    logic                tick;
    logic [SC_W-1:0]     settle_q, settle_d;
    logic [NUM_CH-1:0]   round_mask, round_d;
    logic [CH_W-1:0]     mux_d, ch_d, first_ch, next_ch;
    logic                next_hit;
    logic [7:0]          data_d;
    logic                valid_d;

    // A period of 0 behaves as 1, i.e. a tick every enabled cycle.
    assign per_last = (period == '0) ? '0 : (period - PER_W'(1));
    assign tick     = enable && (tcnt_q == per_last);
    assign busy     = (state_q != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt_q <= '0;
        end else if (!enable || (tcnt_q >= per_last)) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_q + PER_W'(1);
        end
    end

    // Handshake: a sample transfers on any edge where sample_valid && sample_ready;
    // sample_data/sample_ch hold steady while sample_valid is high.
    always_comb begin
        state_d  = state_q;
        mux_d    = mux_sel;
        settle_d = settle_q;
        round_d  = round_mask;
        data_d   = sample_data;
        ch_d     = sample_ch;
        valid_d  = sample_valid;

        first_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) first_ch = CH_W'(i);
        end

        next_ch  = '0;
        next_hit = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (round_mask[i] && (CH_W'(i) > mux_sel)) begin
                next_ch  = CH_W'(i);
                next_hit = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (tick && (ch_mask != '0)) begin
                    round_d  = ch_mask;
                    mux_d    = first_ch;
                    settle_d = SC_LOAD;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_q == '0) begin
                    data_d  = adc_data;
                    ch_d    = mux_sel;
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end else begin
                    settle_d = settle_q - SC_W'(1);
                end
            end
            S_HOLD: begin
                if (sample_valid && sample_ready) begin
                    valid_d = 1'b0;
                    if (next_hit) begin
                        mux_d    = next_ch;
                        settle_d = SC_LOAD;
                        state_d  = S_SETTLE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            mux_sel      <= '0;
            settle_q     <= '0;
            round_mask   <= '0;
            sample_data  <= '0;
            sample_ch    <= '0;
            sample_valid <= 1'b0;
        end else begin
            state_q      <= state_d;
            mux_sel      <= mux_d;
            settle_q     <= settle_d;
            round_mask   <= round_d;
            sample_data  <= data_d;
            sample_ch    <= ch_d;
            sample_valid <= valid_d;
        end
    end

    // A tick that lands while a round is still running is dropped and flagged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end else if (tick && busy) begin
            overrun <= 1'b1;
        end
    end

`ifdef DATA_SAMPLE_SCHED_OVERRUN_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_cnt <= '0;
        end else if (clr_overrun) begin
            overrun_cnt <= '0;
        end else if (tick && busy && (overrun_cnt != 8'hFF)) begin
            overrun_cnt <= overrun_cnt + 8'd1;
        end
    end
`else
    assign overrun_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_data_sample_scheduler.sv
// Bench for data_sample_scheduler: a cycle-level reference model predicts rounds, sample timing and overruns;
// a negedge monitor compares the DUT against it and pops expected samples on each transfer.
module tb_data_sample_scheduler;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int SETTLE = 2;
    localparam int PER_W  = 16;
    localparam int W      = CH_W + 8;
`ifdef DATA_SAMPLE_SCHED_OVERRUN_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              enable;
    logic [PER_W-1:0]  period;
    logic [NUM_CH-1:0] ch_mask;
    logic [7:0]        adc_data;
    logic [CH_W-1:0]   mux_sel;
    logic [7:0]        sample_data;
    logic [CH_W-1:0]   sample_ch;
    logic              sample_valid;
    logic              sample_ready;
    logic              busy;
    logic              clr_overrun;
    logic              overrun;
    logic [7:0]        overrun_cnt;

    logic [7:0]   chan_val [NUM_CH];
    logic [W-1:0] exp_q[$];

    int total = 0;
    int bad   = 0;

    // reference model state
    int cyc   = 0;
    int rem   = 0;
    int due   = 0;
    int tc    = 0;
    int m_cnt = 0;
    bit m_ovr = 1'b0;
    int pe;
    bit tick_m;
    bit was_busy;
    bit mv;

    data_sample_scheduler #(
        .NUM_CH(NUM_CH),
        .CH_W  (CH_W),
        .SETTLE(SETTLE),
        .PER_W (PER_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .period      (period),
        .ch_mask     (ch_mask),
        .adc_data    (adc_data),
        .mux_sel     (mux_sel),
        .sample_data (sample_data),
        .sample_ch   (sample_ch),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .busy        (busy),
        .clr_overrun (clr_overrun),
        .overrun     (overrun),
        .overrun_cnt (overrun_cnt)
    );

    // analog front end: each channel presents its own value on the shared path
    assign adc_data = chan_val[mux_sel];

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_checks();
        chk("rst_mux_sel", 32'(mux_sel), 0);
        chk("rst_sample_data", 32'(sample_data), 0);
        chk("rst_sample_ch", 32'(sample_ch), 0);
        chk("rst_sample_valid", 32'(sample_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_overrun_cnt", 32'(overrun_cnt), 0);
    endtask

    task automatic reseed_channels();
        for (int i = 0; i < NUM_CH; i++) chan_val[i] = 8'(8'h40 * i + $urandom_range(0, 63));
    endtask

    // Reference model: advances one clock edge using only bench-side values.
    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            rem   = 0;
            due   = 0;
            tc    = 0;
            m_ovr = 1'b0;
            m_cnt = 0;
        end else begin
            pe       = (period == '0) ? 1 : int'(period);
            tick_m   = enable && (tc == pe - 1);
            was_busy = (rem > 0);
            mv       = (rem > 0) && (cyc >= due);
            if (mv && sample_ready) begin
                rem--;
                due = cyc + 1 + SETTLE;
            end
            if (tick_m) begin
                if (was_busy) begin
                    m_ovr = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                end else if (ch_mask != '0) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (ch_mask[i]) begin
                            exp_q.push_back({CH_W'(i), chan_val[i]});
                            rem++;
                        end
                    end
                    due = cyc + 1 + SETTLE;
                end
            end
            if (clr_overrun) begin
                m_ovr = 1'b0;
                m_cnt = 0;
            end
            if (!enable || (tc >= pe - 1)) tc = 0;
            else tc++;
        end
        cyc++;
    end

    // Monitor / scoreboard: compare on the falling edge, pop on each transfer.
    always @(negedge clk) begin
        if (!reset) begin
            chk("busy", 32'(busy), 32'(rem > 0));
            chk("sample_valid", 32'(sample_valid), 32'((rem > 0) && (cyc >= due)));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("overrun_cnt", 32'(overrun_cnt), CNT_EN ? 32'(m_cnt) : 32'd0);
            if ((rem > 0) && (exp_q.size() > 0)) chk("mux_sel", 32'(mux_sel), 32'(exp_q[0][W-1:8]));
            if (sample_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_sample actual=ch%0d/%0h required=none", sample_ch, sample_data);
                end else begin
                    chk("sample_ch", 32'(sample_ch), 32'(exp_q[0][W-1:8]));
                    chk("sample_data", 32'(sample_data), 32'(exp_q[0][7:0]));
                    if (sample_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // driver
    initial begin
        reset        = 1'b0;
        enable       = 1'b0;
        period       = '0;
        ch_mask      = '0;
        sample_ready = 1'b0;
        clr_overrun  = 1'b0;
        reseed_channels();
        #1 reset = 1'b1;
        #2 reset_checks();
        step(3);
        reset = 1'b0;

        // basic round
        period = 16'd20; ch_mask = 4'b1011; sample_ready = 1'b1; enable = 1'b1;
        step(70);

        // backpressure with random ready, period and mask
        for (int r = 0; r < 200; r++) begin
            sample_ready = ($urandom_range(0, 2) != 0);
            if (r % 25 == 0) begin
                period  = 16'($urandom_range(6, 40));
                ch_mask = 4'($urandom_range(1, 15));
            end
            step(1);
        end

        // overrun saturation, then clear
        sample_ready = 1'b0; period = 16'd4; ch_mask = 4'hF;
        step(1250);
        clr_overrun = 1'b1; enable = 1'b0;
        step(1);
        clr_overrun = 1'b0; sample_ready = 1'b1;
        step(20);

        // empty mask, then period 0
        enable = 1'b1; ch_mask = '0; period = 16'd3;
        step(30);
        period = '0; ch_mask = 4'b0001;
        step(30);

        // enable drop mid-round
        ch_mask = 4'hF; period = 16'd30;
        step(40);
        for (int k = 0; k < 100 && !busy; k++) step(1);
        chk("round_started", 32'(busy), 1);
        step(5);
        enable = 1'b0;
        step(60);
        enable = 1'b1;
        step(60);

        // period shrink below the running count
        period = 16'd50;
        step(40);
        period = 16'd10;
        step(40);

        // reset during settle of channel 2
        period = 16'd10; ch_mask = 4'hF; sample_ready = 1'b1;
        for (int k = 0; k < 200 && !(busy && mux_sel == 2'd2 && !sample_valid); k++) step(1);
        chk("reach_ch2_settle", 32'(busy && mux_sel == 2'd2 && !sample_valid), 1);
        reset = 1'b1;
        #1 reset_checks();
        reseed_channels();
        step(2);
        reset = 1'b0;
        step(40);

        // random traffic
        for (int r = 0; r < 3000; r++) begin
            sample_ready = ($urandom_range(0, 3) != 0);
            enable       = ($urandom_range(0, 99) < 97);
            clr_overrun  = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 49) == 0) begin
                period  = 16'($urandom_range(0, 30));
                ch_mask = 4'($urandom_range(0, 15));
            end
            step(1);
        end
        clr_overrun = 1'b0;
        step(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
